hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // M wins over W so the youngest producer is forwarded; x0 never forwards.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wen_m,
    input logic [4:0] rd_w,
    input logic       wen_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (wen_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wen_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Pipeline-side signal bundle between the datapath and hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0] RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MemReqM, MemReadyM;

  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  fwd_sel_t   ForwardAE, ForwardBE;
  logic       MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );

endinterface

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : E-stage forwarding select for a single source operand.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output fwd_sel_t   fwd_o
);

  always_comb begin
    fwd_o = fwd_select(rs_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush/forwarding sequencer for the 5-stage core; freezes
//            the pipe on outstanding data-memory accesses and halts on timeout.
//            Define HAZARD_PERF_EN to add the PerfStall/PerfFlush counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] PerfStall,
  output logic [CNT_W-1:0] PerfFlush
`endif
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t        state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic timeout;
  logic miss, load_use;
  fwd_sel_t fwd_a, fwd_b;

  hazard_fwd_unit u_fwd_a (
    .rs_i          (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_i          (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign miss     = hz.MemReqM && !hz.MemReadyM;
  assign load_use = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      RUN: begin
        if (miss) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = TO_W'(1);
        end else if (hz.PCSrcE) begin
          // A taken branch makes the D instruction wrong-path, so load-use is moot.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Exit cycle releases everything; branch/load-use resume next cycle.
        if (hz.MemReadyM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
          cnt_d   = cnt_q + TO_W'(1);
          if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
        timeout = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are gated so they read zero for the whole time reset is held.
  assign hz.StallF     = rst_n & stall_f;
  assign hz.StallD     = rst_n & stall_d;
  assign hz.StallE     = rst_n & stall_e;
  assign hz.StallM     = rst_n & stall_m;
  assign hz.FlushD     = rst_n & flush_d;
  assign hz.FlushE     = rst_n & flush_e;
  assign hz.FlushW     = rst_n & flush_w;
  assign hz.MemTimeout = rst_n & timeout;
  assign hz.ForwardAE  = rst_n ? fwd_a : FWD_RF;
  assign hz.ForwardBE  = rst_n ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (state_q != HALT) begin
      if (stall_f) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
      if (flush_d || flush_e) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
    end
  end

  assign PerfStall = perf_stall_q;
  assign PerfFlush = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MEM_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
`ifdef HAZARD_PERF_EN
    ,
    .PerfStall (perf_stall),
    .PerfFlush (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemTimeout}
  wire [7:0] ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                    hz.FlushD, hz.FlushE, hz.FlushW, hz.MemTimeout};
  wire [1:0] fa  = hz.ForwardAE;
  wire [1:0] fb  = hz.ForwardBE;

  task automatic idle();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1;
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 8'h00); end
    checks++; if (fa !== 2'b00 || fb !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b/%b exp 00/00", fa, fb); end
`ifdef HAZARD_PERF_EN
    checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d exp 0/0", perf_stall, perf_flush); end
`endif
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    @(negedge clk); idle();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
    #1;
    checks++; if (fa !== 2'b10 || fb !== 2'b10) begin errors++; $display("FAIL fwd_m_priority: got %b/%b exp 10/10", fa, fb); end
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL fwd_no_stall: got %b exp %b", ctl, 8'h00); end
    @(negedge clk); hz.RegWriteM = 1'b0;
    #1;
    checks++; if (fa !== 2'b01 || fb !== 2'b01) begin errors++; $display("FAIL fwd_w_only: got %b/%b exp 01/01", fa, fb); end
    @(negedge clk); idle();
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    #1;
    checks++; if (fa !== 2'b00 || fb !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b/%b exp 00/00", fa, fb); end
    @(negedge clk); idle();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd7;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd7;
    #1;
    checks++; if (fa !== 2'b10 || fb !== 2'b01) begin errors++; $display("FAIL fwd_split: got %b/%b exp 10/01", fa, fb); end
    @(negedge clk); hz.RegWriteW = 1'b0; hz.Rs1E = 5'd9;
    #1;
    checks++; if (fa !== 2'b00 || fb !== 2'b00) begin errors++; $display("FAIL fwd_none: got %b/%b exp 00/00", fa, fb); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle();
    hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd6; hz.Rs2D = 5'd6;
    #1;
    checks++; if (ctl !== 8'hC4) begin errors++; $display("FAIL load_use_stall: got %b exp %b", ctl, 8'hC4); end
    @(negedge clk); hz.ResultSrcE = 2'b00; hz.RdE = 5'd0;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL load_use_release: got %b exp %b", ctl, 8'h00); end
    @(negedge clk); idle();
    hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL load_use_x0: got %b exp %b", ctl, 8'h00); end
  endtask

  task automatic test_branch_override();
    @(negedge clk); idle();
    hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd6; hz.Rs1D = 5'd6; hz.PCSrcE = 1'b1;
    #1;
    checks++; if (ctl !== 8'h0C) begin errors++; $display("FAIL branch_over_load_use: got %b exp %b", ctl, 8'h0C); end
  endtask

  task automatic test_mem_wait();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle();
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = (k != 0);
      #1;
      checks++; if (ctl !== 8'hF2) begin errors++; $display("FAIL mem_wait_stall[%0d]: got %b exp %b", k, ctl, 8'hF2); end
    end
    @(negedge clk); idle();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1; hz.PCSrcE = 1'b1;
    hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd6; hz.Rs1D = 5'd6;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL mem_wait_exit: got %b exp %b", ctl, 8'h00); end
    @(negedge clk); idle(); hz.PCSrcE = 1'b1;
    #1;
    checks++; if (ctl !== 8'h0C) begin errors++; $display("FAIL mem_wait_back_to_run: got %b exp %b", ctl, 8'h0C); end
  endtask

  task automatic test_same_cycle_ready();
    @(negedge clk); idle(); hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL hit_no_stall: got %b exp %b", ctl, 8'h00); end
    @(negedge clk); idle(); hz.PCSrcE = 1'b1;
    #1;
    checks++; if (ctl !== 8'h0C) begin errors++; $display("FAIL hit_stays_run: got %b exp %b", ctl, 8'h0C); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [5] = '{8'hF2, 8'h00, 8'hF2, 8'hF2, 8'h00};
    logic       rdy_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); hz.MemReqM = 1'b1; hz.MemReadyM = rdy_seq[k];
      #1;
      checks++; if (ctl !== exp_seq[k]) begin errors++; $display("FAIL back_to_back[%0d]: got %b exp %b", k, ctl, exp_seq[k]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); idle(); hz.MemReqM = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ctl !== 8'hF2) begin errors++; $display("FAIL mid_wait_pre: got %b exp %b", ctl, 8'hF2); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL mid_wait_async_reset: got %b exp %b", ctl, 8'h00); end
    @(negedge clk); idle(); rst_n = 1'b1;
    @(negedge clk); hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1; hz.PCSrcE = 1'b1;
    #1;
    checks++; if (ctl !== 8'h0C) begin errors++; $display("FAIL mid_wait_run_after: got %b exp %b", ctl, 8'h0C); end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      @(negedge clk); idle(); hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
      #1;
      checks++; if (ctl !== 8'hF2) begin errors++; $display("FAIL timeout_wait[%0d]: got %b exp %b", k, ctl, 8'hF2); end
    end
    @(negedge clk);
    #1;
    checks++; if (ctl !== 8'hF3) begin errors++; $display("FAIL timeout_halt: got %b exp %b", ctl, 8'hF3); end
    @(negedge clk); idle(); hz.MemReadyM = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ctl !== 8'hF3) begin errors++; $display("FAIL timeout_sticky: got %b exp %b", ctl, 8'hF3); end
    @(negedge clk); rst_n = 1'b0;
    hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs1E = 5'd3;
    #1;
    checks++; if (ctl !== 8'h00 || fa !== 2'b00) begin errors++; $display("FAIL timeout_reset: got %b/%b exp %b/00", ctl, fa, 8'h00); end
    @(negedge clk); idle(); rst_n = 1'b1;
    @(negedge clk); hz.PCSrcE = 1'b1;
    #1;
    checks++; if (ctl !== 8'h0C) begin errors++; $display("FAIL timeout_run_after_reset: got %b exp %b", ctl, 8'h0C); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle();
      hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd6; hz.Rs2D = 5'd6;
    end
    @(negedge clk); idle(); hz.PCSrcE = 1'b1;
    @(negedge clk); idle();
    #1;
    checks++; if (perf_stall !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d exp 2", perf_stall); end
    checks++; if (perf_flush !== 32'd3) begin errors++; $display("FAIL perf_flush: got %0d exp 3", perf_flush); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_mem_wait();
    test_same_cycle_ready();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
